// File: rtl/io_bist_pkg.sv
// io_bist_pkg: shared types and sizing helpers for the IO loopback BIST.
//   bist_state_e    : FSM state encoding (IDLE, DRIVE, SAMPLE, DONE)
//   DM_INPUT        : pad drive mode while tri-stated (input only)
//   DM_BIDIR        : pad drive mode while a pattern is driven
//   npat_f(n)       : number of test patterns for n pads
//   idx_w_f(n)      : width of the pattern index for n pads
// Optional feature: IO_BIST_WALK_EN adds walking-one / walking-zero patterns.
package io_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_e;

  localparam logic [2:0] DM_INPUT = 3'b001;
  localparam logic [2:0] DM_BIDIR = 3'b110;

  function automatic int npat_f(input int n);
`ifdef IO_BIST_WALK_EN
    return 4 + 2 * n;
`else
    // pad count only matters once walking patterns are enabled
    return (n < 0) ? 0 : 4;
`endif
  endfunction

  function automatic int idx_w_f(input int n);
`ifdef IO_BIST_WALK_EN
    return $clog2(4 + 2 * n);
`else
    return (n < 0) ? 0 : 2;
`endif
  endfunction

endpackage

// File: rtl/io_loopback_bist_if.sv
// io_loopback_bist_if: pad-side bundle of the loopback BIST.
//   pad_out     : data driven onto the pads
//   pad_oeb     : output enable, active low
//   pad_inp_dis : input buffer disable
//   pad_dm      : drive mode, 3 bits per pad
//   pad_in      : value read back from the pads
// master = BIST core, slave = pad ring.
interface io_loopback_bist_if #(
  parameter int NUM_PADS = 37
);
  logic [NUM_PADS-1:0]   pad_out;
  logic [NUM_PADS-1:0]   pad_oeb;
  logic [NUM_PADS-1:0]   pad_inp_dis;
  logic [3*NUM_PADS-1:0] pad_dm;
  logic [NUM_PADS-1:0]   pad_in;

  modport master (
    output pad_out, pad_oeb, pad_inp_dis, pad_dm,
    input  pad_in
  );

  modport slave (
    input  pad_out, pad_oeb, pad_inp_dis, pad_dm,
    output pad_in
  );
endinterface

// File: rtl/io_bist_pattern_gen.sv
// io_bist_pattern_gen: combinational map from pattern index to pad pattern.
//   idx_i : pattern index
//   pat_o : NUM_PADS-bit pattern
// Base set: 0 all-zero, 1 all-one, 2 bit i = i[0], 3 inverse of 2.
// With IO_BIST_WALK_EN: walking-one then walking-zero across all pads.
module io_bist_pattern_gen
  import io_bist_pkg::*;
#(
  parameter int NUM_PADS = 37,
  parameter int IDX_W    = idx_w_f(NUM_PADS)
) (
  input  logic [IDX_W-1:0]    idx_i,
  output logic [NUM_PADS-1:0] pat_o
);

  always_comb begin
    int p;
    p     = int'(idx_i);
    pat_o = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (p == 0)      pat_o[i] = 1'b0;
      else if (p == 1) pat_o[i] = 1'b1;
      else if (p == 2) pat_o[i] = i[0];
      else if (p == 3) pat_o[i] = ~i[0];
`ifdef IO_BIST_WALK_EN
      else if (p < 4 + NUM_PADS) pat_o[i] = (i == p - 4);
      else                       pat_o[i] = (i != p - 4 - NUM_PADS);
`endif
    end
  end

endmodule

// File: rtl/io_loopback_bist.sv
// io_loopback_bist: drives test patterns onto the user pads, reads them back
// after a settle time and accumulates per-pad and total mismatches.
//   clock, resetn : clock, synchronous active-low reset
//   start_i       : begin a run (honoured in IDLE only)
//   abort_i       : terminate the run, back to IDLE
//   pads          : pad bundle (master side)
//   busy_o        : pattern drive in progress
//   done_o        : one-cycle pulse at run completion
//   pass_o        : last completed run saw no mismatches
//   fail_mask_o   : sticky per-pad mismatch flags
//   err_count_o   : saturating count of mismatching bits
// Optional feature: IO_BIST_WALK_EN (walking-one/zero patterns).
module io_loopback_bist
  import io_bist_pkg::*;
#(
  parameter int NUM_PADS      = 37,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start_i,
  input  logic                abort_i,
  io_loopback_bist_if.master  pads,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [NUM_PADS-1:0] fail_mask_o,
  output logic [ERR_W-1:0]    err_count_o
);

  localparam int NPAT  = npat_f(NUM_PADS);
  localparam int IDX_W = idx_w_f(NUM_PADS);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CNT_W = $clog2(NUM_PADS + 1);
  localparam int SUM_W = ((ERR_W > CNT_W) ? ERR_W : CNT_W) + 1;

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NPAT - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SUM_W-1:0] ERR_MAX     = SUM_W'({ERR_W{1'b1}});

  bist_state_e         state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [SET_W-1:0]    settle_q;
  logic [NUM_PADS-1:0] pat_q;
  logic                busy_q, done_q, pass_q;
  logic [NUM_PADS-1:0] fail_mask_q, fail_mask_d;
  logic [ERR_W-1:0]    err_count_q, err_count_d;

  logic [IDX_W-1:0]    idx_nxt;
  logic [NUM_PADS-1:0] pat_w;
  logic [NUM_PADS-1:0] diff;
  logic [CNT_W-1:0]    pop;
  logic [SUM_W-1:0]    err_sum;

  // Generator looks one step ahead so pat_q is loaded on the edge that
  // enters DRIVE and the pads see the new pattern on the first DRIVE cycle.
  io_bist_pattern_gen #(
    .NUM_PADS (NUM_PADS),
    .IDX_W    (IDX_W)
  ) u_pat (
    .idx_i (idx_nxt),
    .pat_o (pat_w)
  );

  always_comb begin
    idx_nxt = idx_q;
    if (state_q == IDLE)   idx_nxt = '0;
    if (state_q == SAMPLE) idx_nxt = idx_q + IDX_W'(1);

    diff = pads.pad_in ^ pat_q;
    pop  = '0;
    for (int i = 0; i < NUM_PADS; i++) pop = pop + CNT_W'(diff[i]);

    err_sum     = SUM_W'(err_count_q) + SUM_W'(pop);
    err_count_d = (err_sum > ERR_MAX) ? '1 : err_sum[ERR_W-1:0];
    fail_mask_d = fail_mask_q | diff;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      settle_q    <= '0;
      pat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      err_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // abort has priority over a coincident start
          if (start_i && !abort_i) begin
            fail_mask_q <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
            idx_q       <= '0;
            settle_q    <= '0;
            pat_q       <= pat_w;
            busy_q      <= 1'b1;
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pat_q   <= '0;
            pass_q  <= 1'b0;
          end else if (settle_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        SAMPLE: begin
          if (abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pat_q   <= '0;
            pass_q  <= 1'b0;
          end else begin
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
            settle_q    <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              pat_q   <= '0;
              done_q  <= 1'b1;
              pass_q  <= (fail_mask_d == '0);
            end else begin
              idx_q   <= idx_nxt;
              pat_q   <= pat_w;
              state_q <= DRIVE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (abort_i) pass_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // pad controls decode straight from flops so reset tri-states the pads
  // on the same edge it is sampled
  assign pads.pad_out     = pat_q;
  assign pads.pad_oeb     = {NUM_PADS{~busy_q}};
  assign pads.pad_inp_dis = '0;
  assign pads.pad_dm      = busy_q ? {NUM_PADS{DM_BIDIR}} : {NUM_PADS{DM_INPUT}};

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_mask_o = fail_mask_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_io_loopback_bist.sv
// tb_io_loopback_bist: self-checking bench for io_loopback_bist.
// Pads are looped back through stuck-at-0 / stuck-at-1 fault masks; a
// pattern-list model predicts fail_mask, err_count, pass and timing.
module tb_io_loopback_bist;
  localparam int NP = 37;
  localparam int S  = 2;
`ifdef IO_BIST_WALK_EN
  localparam int NPAT = 4 + 2 * NP;
`else
  localparam int NPAT = 4;
`endif
  localparam int RUN = NPAT * (S + 1);

  logic clock = 1'b0;
  logic resetn, start, abort, start4;
  logic [NP-1:0] s0, s1;
  logic busy, done, pass, busy4, done4, pass4;
  logic [NP-1:0] fm, fm4;
  logic [7:0] ec;
  logic [3:0] ec4;
  int vec = 0;
  int miscmp = 0;

  io_loopback_bist_if #(.NUM_PADS(NP)) pif ();
  io_loopback_bist_if #(.NUM_PADS(NP)) pif4 ();
  assign pif.pad_in  = (pif.pad_out & ~s0) | s1;
  assign pif4.pad_in = '1;

  always #5 clock = ~clock;

  io_loopback_bist #(.NUM_PADS(NP), .SETTLE_CYCLES(S), .ERR_W(8)) dut (
    .clock(clock), .resetn(resetn), .start_i(start), .abort_i(abort), .pads(pif),
    .busy_o(busy), .done_o(done), .pass_o(pass), .fail_mask_o(fm), .err_count_o(ec));

  io_loopback_bist #(.NUM_PADS(NP), .SETTLE_CYCLES(S), .ERR_W(4)) dut4 (
    .clock(clock), .resetn(resetn), .start_i(start4), .abort_i(1'b0), .pads(pif4),
    .busy_o(busy4), .done_o(done4), .pass_o(pass4), .fail_mask_o(fm4), .err_count_o(ec4));

  function automatic logic [NP-1:0] mpat(input int p);
    logic [NP-1:0] v;
    v = '0;
    if (p == 0) v = '0;
    else if (p == 1) v = '1;
    else if (p == 2 || p == 3) begin
      for (int i = 0; i < NP; i++) v[i] = (i % 2 == 1);
      if (p == 3) v = ~v;
    end
`ifdef IO_BIST_WALK_EN
    else if (p < 4 + NP) v[p-4] = 1'b1;
    else begin v = '1; v[p-4-NP] = 1'b0; end
`endif
    return v;
  endfunction

  // expected accumulators after the first npats patterns are sampled
  task automatic model(input logic [NP-1:0] m0, input logic [NP-1:0] m1, input int npats,
                       input int emax, output logic [NP-1:0] efm, output int eec);
    logic [NP-1:0] pat, d;
    efm = '0; eec = 0;
    for (int p = 0; p < npats; p++) begin
      pat = mpat(p);
      d   = ((pat & ~m0) | m1) ^ pat;
      efm = efm | d;
      eec = eec + $countones(d);
      if (eec > emax) eec = emax;
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // drives one run and records timing/drive observations, no judging here
  task automatic run(input bit mid_start, output int dcyc, output int ndone, output int nbad);
    int p;
    start = 1'b1; tick(); start = 1'b0;
    dcyc = -1; ndone = 0; nbad = 0;
    for (int cyc = 1; cyc <= RUN + 5; cyc++) begin
      if (cyc <= RUN) begin
        p = (cyc - 1) / (S + 1);
        if (pif.pad_out !== mpat(p) || pif.pad_oeb !== '0 || busy !== 1'b1 ||
            pif.pad_dm !== {NP{3'b110}} || pif.pad_inp_dis !== '0) nbad++;
      end
      if (done === 1'b1) begin ndone++; if (dcyc < 0) dcyc = cyc; end
      start = (mid_start && cyc == 5);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0; start4 = 1'b0; s0 = '0; s1 = '0;
    tick(); tick();
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL rst_busy got %b want 0", busy); end
    vec++; if (done !== 1'b0) begin miscmp++; $display("FAIL rst_done got %b want 0", done); end
    vec++; if (pass !== 1'b0) begin miscmp++; $display("FAIL rst_pass got %b want 0", pass); end
    vec++; if (fm !== '0) begin miscmp++; $display("FAIL rst_fm got %h want 0", fm); end
    vec++; if (ec !== 8'd0) begin miscmp++; $display("FAIL rst_ec got %0d want 0", ec); end
    vec++; if (pif.pad_oeb !== '1) begin miscmp++; $display("FAIL rst_oeb got %h want all ones", pif.pad_oeb); end
    vec++; if (pif.pad_inp_dis !== '0) begin miscmp++; $display("FAIL rst_inpdis got %h want 0", pif.pad_inp_dis); end
    vec++; if (pif.pad_dm !== {NP{3'b001}}) begin miscmp++; $display("FAIL rst_dm got %h want 001s", pif.pad_dm); end
    vec++; if (pif.pad_out !== '0) begin miscmp++; $display("FAIL rst_out got %h want 0", pif.pad_out); end
    resetn = 1'b1; tick();
    vec++; if (busy !== 1'b0 || pif.pad_oeb !== '1) begin miscmp++; $display("FAIL idle_after_rst busy %b oeb %h want 0/ones", busy, pif.pad_oeb); end
  endtask

  task automatic test_loopback();
    int dc, nd, nb;
    s0 = '0; s1 = '0;
    run(1'b0, dc, nd, nb);
    vec++; if (dc !== RUN + 1) begin miscmp++; $display("FAIL lb_done_cycle got %0d want %0d", dc, RUN + 1); end
    vec++; if (nd !== 1) begin miscmp++; $display("FAIL lb_done_pulses got %0d want 1", nd); end
    vec++; if (nb !== 0) begin miscmp++; $display("FAIL lb_drive got %0d bad cycles want 0", nb); end
    vec++; if (pass !== 1'b1) begin miscmp++; $display("FAIL lb_pass got %b want 1", pass); end
    vec++; if (ec !== 8'd0) begin miscmp++; $display("FAIL lb_ec got %0d want 0", ec); end
    vec++; if (fm !== '0) begin miscmp++; $display("FAIL lb_fm got %h want 0", fm); end
    tick(); tick(); tick();
    vec++; if (pass !== 1'b1) begin miscmp++; $display("FAIL lb_pass_hold got %b want 1", pass); end
  endtask

  task automatic test_stuck();
    int dc, nd, nb, eec;
    logic [NP-1:0] efm;
    s0 = NP'(1) << 5; s1 = '0;
    model(s0, s1, NPAT, 255, efm, eec);
    run(1'b0, dc, nd, nb);
    vec++; if (fm !== efm) begin miscmp++; $display("FAIL stuck_fm got %h want %h", fm, efm); end
    vec++; if (int'(ec) !== eec) begin miscmp++; $display("FAIL stuck_ec got %0d want %0d", ec, eec); end
    vec++; if (pass !== 1'b0) begin miscmp++; $display("FAIL stuck_pass got %b want 0", pass); end
    vec++; if (dc !== RUN + 1) begin miscmp++; $display("FAIL stuck_done_cycle got %0d want %0d", dc, RUN + 1); end
  endtask

  task automatic test_random();
    int dc, nd, nb, eec;
    logic [NP-1:0] efm;
    logic [63:0] r0, r1, r2;
    for (int k = 0; k < 8; k++) begin
      r0 = {$urandom(), $urandom()}; r1 = {$urandom(), $urandom()}; r2 = {$urandom(), $urandom()};
      s0 = r0[NP-1:0] & r1[NP-1:0];
      s1 = r2[NP-1:0] & r1[NP+4:5] & ~s0;
      if (k == 0) begin s0 = '0; s1 = '0; end
      model(s0, s1, NPAT, 255, efm, eec);
      run(1'b0, dc, nd, nb);
      vec++; if (fm !== efm) begin miscmp++; $display("FAIL rnd%0d_fm got %h want %h", k, fm, efm); end
      vec++; if (int'(ec) !== eec) begin miscmp++; $display("FAIL rnd%0d_ec got %0d want %0d", k, ec, eec); end
      vec++; if (pass !== (efm == '0)) begin miscmp++; $display("FAIL rnd%0d_pass got %b want %b", k, pass, efm == '0); end
      vec++; if (nd !== 1 || nb !== 0) begin miscmp++; $display("FAIL rnd%0d_run got done %0d bad %0d want 1/0", k, nd, nb); end
    end
  endtask

  task automatic test_abort();
    int nd, eec;
    logic [NP-1:0] efm;
    s0 = '0; s1 = NP'(1) << 3;
    model(s0, s1, 1, 255, efm, eec);
    start = 1'b1; tick(); start = 1'b0;
    for (int cyc = 1; cyc < 4; cyc++) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL abort_busy got %b want 0", busy); end
    vec++; if (pif.pad_oeb !== '1) begin miscmp++; $display("FAIL abort_oeb got %h want all ones", pif.pad_oeb); end
    vec++; if (pass !== 1'b0) begin miscmp++; $display("FAIL abort_pass got %b want 0", pass); end
    vec++; if (fm !== efm) begin miscmp++; $display("FAIL abort_fm got %h want %h", fm, efm); end
    vec++; if (int'(ec) !== eec) begin miscmp++; $display("FAIL abort_ec got %0d want %0d", ec, eec); end
    nd = 0;
    for (int i = 0; i < 20; i++) begin if (done === 1'b1) nd++; tick(); end
    vec++; if (nd !== 0) begin miscmp++; $display("FAIL abort_no_done got %0d pulses want 0", nd); end
  endtask

  task automatic test_start_busy();
    int dc, nd, nb;
    s0 = '0; s1 = '0;
    run(1'b1, dc, nd, nb);
    vec++; if (dc !== RUN + 1) begin miscmp++; $display("FAIL sbusy_done_cycle got %0d want %0d", dc, RUN + 1); end
    vec++; if (nd !== 1 || nb !== 0) begin miscmp++; $display("FAIL sbusy_run got done %0d bad %0d want 1/0", nd, nb); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL sbusy_no_restart got busy %b want 0", busy); end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL sa_busy got %b want 0", busy); end
    tick();
    vec++; if (busy !== 1'b0 || pif.pad_oeb !== '1) begin miscmp++; $display("FAIL sa_idle busy %b oeb %h want 0/ones", busy, pif.pad_oeb); end
  endtask

  task automatic test_reset_mid();
    s0 = '0; s1 = NP'(1);
    start = 1'b1; tick(); start = 1'b0;
    for (int cyc = 1; cyc < 7; cyc++) tick();
    vec++; if (fm !== NP'(1)) begin miscmp++; $display("FAIL midrst_pre_fm got %h want 1", fm); end
    resetn = 1'b0; tick();
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL midrst_busy got %b want 0", busy); end
    vec++; if (pif.pad_oeb !== '1) begin miscmp++; $display("FAIL midrst_oeb got %h want all ones", pif.pad_oeb); end
    vec++; if (pif.pad_dm !== {NP{3'b001}}) begin miscmp++; $display("FAIL midrst_dm got %h want 001s", pif.pad_dm); end
    vec++; if (fm !== '0 || ec !== 8'd0) begin miscmp++; $display("FAIL midrst_acc got fm %h ec %0d want 0/0", fm, ec); end
    resetn = 1'b1; s1 = '0; tick();
  endtask

  task automatic test_saturate();
    int dc, eec;
    logic [NP-1:0] efm;
    model('0, '1, NPAT, 15, efm, eec);
    start4 = 1'b1; tick(); start4 = 1'b0;
    dc = -1;
    for (int cyc = 1; cyc <= RUN + 10 && dc < 0; cyc++) begin
      if (done4 === 1'b1) dc = cyc; else tick();
    end
    vec++; if (dc !== RUN + 1) begin miscmp++; $display("FAIL sat_done_cycle got %0d want %0d", dc, RUN + 1); end
    vec++; if (int'(ec4) !== eec) begin miscmp++; $display("FAIL sat_ec got %0d want %0d", ec4, eec); end
    vec++; if (fm4 !== efm) begin miscmp++; $display("FAIL sat_fm got %h want %h", fm4, efm); end
    vec++; if (pass4 !== 1'b0) begin miscmp++; $display("FAIL sat_pass got %b want 0", pass4); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_stuck();
    test_random();
    test_abort();
    test_start_busy();
    test_start_abort_idle();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
